// File: rtl/axi_scratchpad_pkg.sv
// Shared FSM state types and AXI response/burst encodings for the scratchpad responder.
package axi_scratchpad_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

endpackage

// File: rtl/axi_bus.sv
// AXI4+ATOP bus bundle with master and slave views.
interface AXI_BUS #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 10,
  parameter int unsigned AXI_USER_WIDTH = 10
);
  localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;
  logic                      aw_lock;
  logic [3:0]                aw_cache;
  logic [2:0]                aw_prot;
  logic [3:0]                aw_qos;
  logic [3:0]                aw_region;
  logic [5:0]                aw_atop;
  logic [AXI_USER_WIDTH-1:0] aw_user;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [AXI_STRB_WIDTH-1:0] w_strb;
  logic                      w_last;
  logic [AXI_USER_WIDTH-1:0] w_user;
  logic                      w_valid;
  logic                      w_ready;

  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [1:0]                b_resp;
  logic [AXI_USER_WIDTH-1:0] b_user;
  logic                      b_valid;
  logic                      b_ready;

  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic                      ar_lock;
  logic [3:0]                ar_cache;
  logic [2:0]                ar_prot;
  logic [3:0]                ar_qos;
  logic [3:0]                ar_region;
  logic [AXI_USER_WIDTH-1:0] ar_user;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic [AXI_USER_WIDTH-1:0] r_user;
  logic                      r_valid;
  logic                      r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
           aw_region, aw_atop, aw_user, aw_valid, input aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid, input w_ready,
    input  b_id, b_resp, b_user, b_valid, output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
           ar_region, ar_user, ar_valid, input ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid, output r_ready
  );

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
           aw_region, aw_atop, aw_user, aw_valid, output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid, output w_ready,
    output b_id, b_resp, b_user, b_valid, input b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
           ar_region, ar_user, ar_valid, output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid, input r_ready
  );
endinterface

// File: rtl/axi_scratchpad_addr_gen.sv
// Combinational beat address decode: word index, range/burst legality and next beat address.
module axi_scratchpad_addr_gen
  import axi_scratchpad_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 64,
  parameter int unsigned           DATA_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 64'h9000_0000,
  parameter int unsigned           NUM_WORDS  = 32
) (
  input  logic [ADDR_WIDTH-1:0]        addr,
  input  logic [2:0]                   size,
  input  logic [1:0]                   burst,
  output logic [ADDR_WIDTH-1:0]        next_addr,
  output logic [$clog2(NUM_WORDS)-1:0] word_idx,
  output logic                         in_range,
  output logic                         burst_ok
);
  localparam int unsigned           IDX_WIDTH = $clog2(NUM_WORDS);
  localparam int unsigned           OFF_BITS  = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] SPAN      = ADDR_WIDTH'(NUM_WORDS * (DATA_WIDTH / 8));
  localparam logic [ADDR_WIDTH-1:0] ONE       = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] offset_s;

  // Decode the current beat; INCR past the end simply walks out of range.
  always_comb begin
    offset_s = addr - BASE_ADDR;
    word_idx = IDX_WIDTH'(offset_s >> OFF_BITS);
    in_range = (addr >= BASE_ADDR) && (offset_s < SPAN);
    burst_ok = (burst != BURST_WRAP);
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_INCR:  next_addr = addr + (ONE << size);
      default:     next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axi_slave_scratchpad.sv
// AXI4 responder backed by a flop scratchpad; independent write and read FSMs share the array.
module axi_slave_scratchpad
  import axi_scratchpad_pkg::*;
#(
  parameter int unsigned               AXI_ID_WIDTH   = 10,
  parameter int unsigned               AXI_ADDR_WIDTH = 64,
  parameter int unsigned               AXI_DATA_WIDTH = 64,
  parameter int unsigned               AXI_USER_WIDTH = 10,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = 64'h9000_0000,
  parameter int unsigned               NUM_WORDS      = 32
) (
  input logic   clk_i,
  input logic   rst_ni,
  AXI_BUS.Slave axi_slave_port
);
  localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;
  localparam int unsigned IDX_WIDTH  = $clog2(NUM_WORDS);

  w_state_e                  w_state_r, w_state_s;
  r_state_e                  r_state_r, r_state_s;
  logic                      ready_en_r;
  logic [AXI_ID_WIDTH-1:0]   w_id_r, r_id_r;
  logic [AXI_ADDR_WIDTH-1:0] w_addr_r, r_addr_r, w_next_addr_s, r_next_addr_s;
  logic [7:0]                w_len_r, w_cnt_r, r_len_r, r_cnt_r;
  logic [2:0]                w_size_r, r_size_r;
  logic [1:0]                w_burst_r, r_burst_r;
  logic [5:0]                w_atop_r;
  logic                      w_err_r;
  logic [IDX_WIDTH-1:0]      w_idx_s, r_idx_s;
  logic                      w_in_range_s, w_burst_ok_s, r_in_range_s, r_burst_ok_s;
  logic                      aw_hs_s, w_hs_s, ar_hs_s, r_hs_s, w_beat_ok_s, r_beat_ok_s;
  logic [AXI_DATA_WIDTH-1:0] mem_r [NUM_WORDS];
  logic                      unused_s;

  axi_scratchpad_addr_gen #(
    .ADDR_WIDTH(AXI_ADDR_WIDTH), .DATA_WIDTH(AXI_DATA_WIDTH),
    .BASE_ADDR(BASE_ADDR), .NUM_WORDS(NUM_WORDS)
  ) u_w_addr_gen (
    .addr(w_addr_r), .size(w_size_r), .burst(w_burst_r), .next_addr(w_next_addr_s),
    .word_idx(w_idx_s), .in_range(w_in_range_s), .burst_ok(w_burst_ok_s)
  );

  axi_scratchpad_addr_gen #(
    .ADDR_WIDTH(AXI_ADDR_WIDTH), .DATA_WIDTH(AXI_DATA_WIDTH),
    .BASE_ADDR(BASE_ADDR), .NUM_WORDS(NUM_WORDS)
  ) u_r_addr_gen (
    .addr(r_addr_r), .size(r_size_r), .burst(r_burst_r), .next_addr(r_next_addr_s),
    .word_idx(r_idx_s), .in_range(r_in_range_s), .burst_ok(r_burst_ok_s)
  );

  // Handshakes are decoded from state so they never depend on our own ready outputs.
  assign aw_hs_s     = (w_state_r == W_IDLE) && ready_en_r && axi_slave_port.aw_valid;
  assign w_hs_s      = (w_state_r == W_DATA) && axi_slave_port.w_valid;
  assign ar_hs_s     = (r_state_r == R_IDLE) && ready_en_r && axi_slave_port.ar_valid;
  assign r_hs_s      = (r_state_r == R_DATA) && axi_slave_port.r_ready;
  assign w_beat_ok_s = w_in_range_s && w_burst_ok_s && (w_atop_r == 6'd0);
  assign r_beat_ok_s = r_in_range_s && r_burst_ok_s;
  assign unused_s    = ^{axi_slave_port.aw_lock, axi_slave_port.aw_cache, axi_slave_port.aw_prot,
                         axi_slave_port.aw_qos, axi_slave_port.aw_region, axi_slave_port.aw_user,
                         axi_slave_port.w_last, axi_slave_port.w_user, axi_slave_port.ar_lock,
                         axi_slave_port.ar_cache, axi_slave_port.ar_prot, axi_slave_port.ar_qos,
                         axi_slave_port.ar_region, axi_slave_port.ar_user};

  // State registers and the post-reset ready enable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state_r  <= W_IDLE;
      r_state_r  <= R_IDLE;
      ready_en_r <= 1'b0;
    end else begin
      w_state_r  <= w_state_s;
      r_state_r  <= r_state_s;
      ready_en_r <= 1'b1;
    end
  end

  // Write next state: the beat counter, not w_last, ends the burst.
  always_comb begin
    w_state_s = w_state_r;
    case (w_state_r)
      W_IDLE:  if (aw_hs_s) w_state_s = W_DATA; else w_state_s = W_IDLE;
      W_DATA:  if (w_hs_s && (w_cnt_r == w_len_r)) w_state_s = W_RESP; else w_state_s = W_DATA;
      W_RESP:  if (axi_slave_port.b_ready) w_state_s = W_IDLE; else w_state_s = W_RESP;
      default: w_state_s = W_IDLE;
    endcase
  end

  // Write channel outputs.
  always_comb begin
    axi_slave_port.aw_ready = 1'b0;
    axi_slave_port.w_ready  = 1'b0;
    axi_slave_port.b_valid  = 1'b0;
    axi_slave_port.b_resp   = RESP_OKAY;
    axi_slave_port.b_id     = w_id_r;
    axi_slave_port.b_user   = {AXI_USER_WIDTH{1'b0}};
    case (w_state_r)
      W_IDLE:  axi_slave_port.aw_ready = ready_en_r;
      W_DATA:  axi_slave_port.w_ready = 1'b1;
      W_RESP: begin
        axi_slave_port.b_valid = 1'b1;
        axi_slave_port.b_resp  = w_err_r ? RESP_SLVERR : RESP_OKAY;
      end
      default: axi_slave_port.b_valid = 1'b0;
    endcase
  end

  // Write request latch, beat address/count advance and sticky error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_id_r    <= {AXI_ID_WIDTH{1'b0}};
      w_addr_r  <= {AXI_ADDR_WIDTH{1'b0}};
      w_len_r   <= 8'd0;
      w_cnt_r   <= 8'd0;
      w_size_r  <= 3'd0;
      w_burst_r <= 2'd0;
      w_atop_r  <= 6'd0;
      w_err_r   <= 1'b0;
    end else if (aw_hs_s) begin
      w_id_r    <= axi_slave_port.aw_id;
      w_addr_r  <= axi_slave_port.aw_addr;
      w_len_r   <= axi_slave_port.aw_len;
      w_cnt_r   <= 8'd0;
      w_size_r  <= axi_slave_port.aw_size;
      w_burst_r <= axi_slave_port.aw_burst;
      w_atop_r  <= axi_slave_port.aw_atop;
      w_err_r   <= 1'b0;
    end else if (w_hs_s) begin
      w_addr_r <= w_next_addr_s;
      w_cnt_r  <= w_cnt_r + 8'd1;
      w_err_r  <= w_err_r | ~w_beat_ok_s;
    end
  end

  // Scratchpad storage with byte-strobed commits.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_WORDS; i++) mem_r[i] <= {AXI_DATA_WIDTH{1'b0}};
    end else if (w_hs_s && w_beat_ok_s) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (axi_slave_port.w_strb[b]) mem_r[w_idx_s][b*8 +: 8] <= axi_slave_port.w_data[b*8 +: 8];
      end
    end
  end

  // Read next state.
  always_comb begin
    r_state_s = r_state_r;
    case (r_state_r)
      R_IDLE:  if (ar_hs_s) r_state_s = R_DATA; else r_state_s = R_IDLE;
      R_DATA:  if (r_hs_s && (r_cnt_r == r_len_r)) r_state_s = R_IDLE; else r_state_s = R_DATA;
      default: r_state_s = R_IDLE;
    endcase
  end

  // Read channel outputs; data comes straight from the array so a same-cycle write is not seen.
  always_comb begin
    axi_slave_port.ar_ready = 1'b0;
    axi_slave_port.r_valid  = 1'b0;
    axi_slave_port.r_last   = 1'b0;
    axi_slave_port.r_data   = {AXI_DATA_WIDTH{1'b0}};
    axi_slave_port.r_resp   = RESP_OKAY;
    axi_slave_port.r_id     = r_id_r;
    axi_slave_port.r_user   = {AXI_USER_WIDTH{1'b0}};
    case (r_state_r)
      R_IDLE:  axi_slave_port.ar_ready = ready_en_r;
      R_DATA: begin
        axi_slave_port.r_valid = 1'b1;
        axi_slave_port.r_last  = (r_cnt_r == r_len_r);
        if (r_beat_ok_s) begin
          axi_slave_port.r_data = mem_r[r_idx_s];
        end else begin
          axi_slave_port.r_resp = RESP_SLVERR;
        end
      end
      default: axi_slave_port.r_valid = 1'b0;
    endcase
  end

  // Read request latch and beat advance on each R handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_id_r    <= {AXI_ID_WIDTH{1'b0}};
      r_addr_r  <= {AXI_ADDR_WIDTH{1'b0}};
      r_len_r   <= 8'd0;
      r_cnt_r   <= 8'd0;
      r_size_r  <= 3'd0;
      r_burst_r <= 2'd0;
    end else if (ar_hs_s) begin
      r_id_r    <= axi_slave_port.ar_id;
      r_addr_r  <= axi_slave_port.ar_addr;
      r_len_r   <= axi_slave_port.ar_len;
      r_cnt_r   <= 8'd0;
      r_size_r  <= axi_slave_port.ar_size;
      r_burst_r <= axi_slave_port.ar_burst;
    end else if (r_hs_s) begin
      r_addr_r <= r_next_addr_s;
      r_cnt_r  <= r_cnt_r + 8'd1;
    end
  end

endmodule

// File: tb/tb_axi_slave_scratchpad.sv
// Directed plus randomized bench for axi_slave_scratchpad against a word-array reference model.
module tb_axi_slave_scratchpad;
  localparam logic [63:0] BASE = 64'h9000_0000;
  localparam int          NW   = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  logic [63:0] model_mem [NW];
  logic [63:0] wdata_q [$];
  logic [7:0]  wstrb_q [$];

  AXI_BUS #(.AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(10), .AXI_USER_WIDTH(10)) bus ();

  axi_slave_scratchpad #(
    .AXI_ID_WIDTH(10), .AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64), .AXI_USER_WIDTH(10),
    .BASE_ADDR(64'h9000_0000), .NUM_WORDS(32)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .axi_slave_port(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] beat_addr(input logic [63:0] a, input int k, input logic [2:0] size,
                                            input logic [1:0] burst);
    if (burst == 2'b01) return a + 64'(k) * (64'd1 << size);
    return a;
  endfunction

  function automatic bit in_rng(input logic [63:0] a);
    return (a >= BASE) && (a < BASE + 64'(NW * 8));
  endfunction

  function automatic int widx(input logic [63:0] a);
    return int'((a - BASE) >> 3);
  endfunction

  task automatic do_write(input logic [9:0] id, input logic [63:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [5:0] atop,
                          input int bstall, input int abort_at);
    bit          err;
    int          t;
    int          idx;
    logic [63:0] a;
    err = 1'b0;
    bus.aw_id = id; bus.aw_addr = addr; bus.aw_len = len; bus.aw_size = size;
    bus.aw_burst = burst; bus.aw_atop = atop; bus.aw_valid = 1'b1;
    t = 0;
    while (bus.aw_ready !== 1'b1 && t < 20) begin step(); t++; end
    chk("aw_ready_wait", bus.aw_ready, 64'd1);
    step();
    bus.aw_valid = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      if ($urandom_range(0, 3) == 0) begin bus.w_valid = 1'b0; step(); end
      bus.w_data = wdata_q[k]; bus.w_strb = wstrb_q[k];
      bus.w_last = (k == int'(len)); bus.w_valid = 1'b1;
      chk("w_ready", bus.w_ready, 64'd1);
      if (k == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("abort_aw_ready", bus.aw_ready, 64'd0);
        chk("abort_w_ready", bus.w_ready, 64'd0);
        chk("abort_b_valid", bus.b_valid, 64'd0);
        chk("abort_ar_ready", bus.ar_ready, 64'd0);
        chk("abort_r_valid", bus.r_valid, 64'd0);
        bus.w_valid = 1'b0;
        for (int i = 0; i < NW; i++) model_mem[i] = 64'd0;
        return;
      end
      step();
      a = beat_addr(addr, k, size, burst);
      if (burst != 2'b10 && atop == 6'd0 && in_rng(a)) begin
        idx = widx(a);
        for (int b = 0; b < 8; b++) begin
          if (wstrb_q[k][b]) model_mem[idx][b*8 +: 8] = wdata_q[k][b*8 +: 8];
        end
      end else begin
        err = 1'b1;
      end
    end
    bus.w_valid = 1'b0;
    chk("b_valid_latency", bus.b_valid, 64'd1);
    chk("b_id", bus.b_id, 64'(id));
    chk("b_resp", bus.b_resp, err ? 64'd2 : 64'd0);
    for (int s = 0; s < bstall; s++) begin
      step();
      chk("b_hold_valid", bus.b_valid, 64'd1);
      chk("b_hold_id", bus.b_id, 64'(id));
      chk("b_hold_aw_ready", bus.aw_ready, 64'd0);
    end
    bus.b_ready = 1'b1;
    step();
    bus.b_ready = 1'b0;
    chk("b_done", bus.b_valid, 64'd0);
  endtask

  task automatic do_read(input logic [9:0] id, input logic [63:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input bit toggle);
    int          k;
    int          t;
    bit          ok;
    logic [63:0] a;
    logic [63:0] exp_d;
    bus.ar_id = id; bus.ar_addr = addr; bus.ar_len = len; bus.ar_size = size;
    bus.ar_burst = burst; bus.ar_valid = 1'b1;
    t = 0;
    while (bus.ar_ready !== 1'b1 && t < 20) begin step(); t++; end
    chk("ar_ready_wait", bus.ar_ready, 64'd1);
    step();
    bus.ar_valid = 1'b0;
    k = 0;
    t = 0;
    while (k <= int'(len) && t < 600) begin
      a     = beat_addr(addr, k, size, burst);
      ok    = (burst != 2'b10) && in_rng(a);
      exp_d = ok ? model_mem[widx(a)] : 64'd0;
      bus.r_ready = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      chk("r_valid", bus.r_valid, 64'd1);
      chk("r_data", bus.r_data, exp_d);
      chk("r_resp", bus.r_resp, ok ? 64'd0 : 64'd2);
      chk("r_last", bus.r_last, (k == int'(len)) ? 64'd1 : 64'd0);
      chk("r_id", bus.r_id, 64'(id));
      step();
      if (bus.r_ready) k++;
      t++;
    end
    chk("r_beat_count", 64'(k), 64'(len) + 64'd1);
    bus.r_ready = 1'b0;
    chk("r_idle_valid", bus.r_valid, 64'd0);
    chk("ar_ready_after", bus.ar_ready, 64'd1);
  endtask

  task automatic load(input int n, input bit rnd);
    wdata_q.delete();
    wstrb_q.delete();
    for (int i = 0; i < n; i++) begin
      wdata_q.push_back(rnd ? {$urandom(), $urandom()} : 64'(i + 1));
      wstrb_q.push_back(rnd ? 8'($urandom_range(0, 255)) : 8'hFF);
    end
  endtask

  initial begin
    logic [63:0] ra;
    logic [7:0]  rl;
    logic [1:0]  rb;
    int          r;
    for (int i = 0; i < NW; i++) model_mem[i] = 64'd0;
    bus.aw_id = 10'd0; bus.aw_addr = 64'd0; bus.aw_len = 8'd0; bus.aw_size = 3'd3;
    bus.aw_burst = 2'b01; bus.aw_lock = 1'b0; bus.aw_cache = 4'd0; bus.aw_prot = 3'd0;
    bus.aw_qos = 4'd0; bus.aw_region = 4'd0; bus.aw_atop = 6'd0; bus.aw_user = 10'd0;
    bus.aw_valid = 1'b0; bus.w_data = 64'd0; bus.w_strb = 8'd0; bus.w_last = 1'b0;
    bus.w_user = 10'd0; bus.w_valid = 1'b0; bus.b_ready = 1'b0;
    bus.ar_id = 10'd0; bus.ar_addr = 64'd0; bus.ar_len = 8'd0; bus.ar_size = 3'd3;
    bus.ar_burst = 2'b01; bus.ar_lock = 1'b0; bus.ar_cache = 4'd0; bus.ar_prot = 3'd0;
    bus.ar_qos = 4'd0; bus.ar_region = 4'd0; bus.ar_user = 10'd0; bus.ar_valid = 1'b0;
    bus.r_ready = 1'b0;

    repeat (3) step();
    chk("rst_aw_ready", bus.aw_ready, 64'd0);
    chk("rst_w_ready", bus.w_ready, 64'd0);
    chk("rst_b_valid", bus.b_valid, 64'd0);
    chk("rst_ar_ready", bus.ar_ready, 64'd0);
    chk("rst_r_valid", bus.r_valid, 64'd0);
    chk("rst_r_last", bus.r_last, 64'd0);
    chk("rst_b_resp", bus.b_resp, 64'd0);
    chk("rst_r_resp", bus.r_resp, 64'd0);
    chk("rst_r_data", bus.r_data, 64'd0);
    chk("rst_b_id", bus.b_id, 64'd0);
    chk("rst_r_id", bus.r_id, 64'd0);
    chk("rst_b_user", bus.b_user, 64'd0);
    chk("rst_r_user", bus.r_user, 64'd0);
    rst_n = 1'b1;
    chk("release_aw_ready", bus.aw_ready, 64'd0);
    step(); step();
    chk("ready_en_aw_ready", bus.aw_ready, 64'd1);
    do_read(10'd1, BASE, 8'd31, 3'd3, 2'b01, 1'b0);

    // Single beat write and readback.
    wdata_q = '{64'hdead_beef_1234_5678}; wstrb_q = '{8'hFF};
    do_write(10'd3, BASE + 64'h8, 8'd0, 3'd3, 2'b01, 6'd0, 0, -1);
    do_read(10'd5, BASE + 64'h8, 8'd0, 3'd3, 2'b01, 1'b0);

    // Four-beat INCR burst.
    load(4, 1'b0);
    do_write(10'd7, BASE + 64'h10, 8'd3, 3'd3, 2'b01, 6'd0, 0, -1);
    do_read(10'd9, BASE + 64'h10, 8'd3, 3'd3, 2'b01, 1'b0);

    // Partial strobe merge into word 0.
    wdata_q = '{64'hFFFF_FFFF_FFFF_FFFF}; wstrb_q = '{8'hFF};
    do_write(10'd2, BASE, 8'd0, 3'd3, 2'b01, 6'd0, 0, -1);
    wdata_q = '{64'h0000_0000_1111_1111}; wstrb_q = '{8'h0F};
    do_write(10'd2, BASE, 8'd0, 3'd3, 2'b01, 6'd0, 0, -1);
    do_read(10'd4, BASE, 8'd0, 3'd3, 2'b01, 1'b0);
    chk("strb_merge_lit", bus.r_data, 64'd0);

    // Error paths: past the end, WRAP, nonzero atop.
    wdata_q = '{64'h5555_5555_5555_5555}; wstrb_q = '{8'hFF};
    do_write(10'd11, BASE + 64'h100, 8'd0, 3'd3, 2'b01, 6'd0, 0, -1);
    do_read(10'd12, BASE + 64'h100, 8'd0, 3'd3, 2'b01, 1'b0);
    load(2, 1'b1);
    do_write(10'd13, BASE, 8'd1, 3'd3, 2'b10, 6'd0, 0, -1);
    do_read(10'd14, BASE, 8'd1, 3'd3, 2'b10, 1'b0);
    load(1, 1'b1);
    do_write(10'd15, BASE + 64'h18, 8'd0, 3'd3, 2'b01, 6'h21, 0, -1);
    do_read(10'd16, BASE, 8'd7, 3'd3, 2'b01, 1'b0);

    // B backpressure and R toggling on an 8-beat read.
    load(8, 1'b1);
    do_write(10'h3A5, BASE + 64'h40, 8'd7, 3'd3, 2'b01, 6'd0, 5, -1);
    do_read(10'h2C3, BASE + 64'h40, 8'd7, 3'd3, 2'b01, 1'b1);

    // Randomized traffic, including bursts that run off the end.
    for (int n = 0; n < 24; n++) begin
      r  = $urandom_range(0, 9);
      rb = (r == 0) ? 2'b10 : (r < 3) ? 2'b00 : 2'b01;
      ra = BASE + 64'($urandom_range(0, 35)) * 64'd8;
      rl = 8'($urandom_range(0, 5));
      load(int'(rl) + 1, 1'b1);
      do_write(10'($urandom), ra, rl, 3'd3, rb, ($urandom_range(0, 7) == 0) ? 6'h10 : 6'd0, $urandom_range(0, 2), -1);
      do_read(10'($urandom), ra, rl, 3'd3, rb, 1'b1);
      do_read(10'($urandom), BASE + 64'($urandom_range(0, 31)) * 64'd8, 8'($urandom_range(0, 7)), 3'd3, 2'b01, 1'b1);
    end

    // Reset in the middle of beat 2 of a four-beat write.
    load(4, 1'b1);
    do_write(10'd6, BASE + 64'h20, 8'd3, 3'd3, 2'b01, 6'd0, 0, 1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rerelease_aw_ready", bus.aw_ready, 64'd0);
    step(); step();
    chk("rerelease_aw_ready_2", bus.aw_ready, 64'd1);
    do_read(10'd8, BASE, 8'd31, 3'd3, 2'b01, 1'b0);
    wdata_q = '{64'h0123_4567_89ab_cdef}; wstrb_q = '{8'hFF};
    do_write(10'd1, BASE + 64'h28, 8'd0, 3'd3, 2'b01, 6'd0, 0, -1);
    do_read(10'd2, BASE + 64'h28, 8'd0, 3'd3, 2'b01, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
